// File: rtl/mash_dsm_cfg.sv
// MASH 1-1-1 delta-sigma modulator with runtime order (0..3), optional LFSR
// dither on the stage-1 LSB, clamped registered output and a valid/ready
// config port. It drives the multi-modulus divider of a fractional-N PLL.
module mash_dsm_cfg #(
  parameter int          ACC_W     = 16,
  parameter int          INT_W     = 4,
  parameter int          OUT_W     = 4,
  parameter int          OUT_MIN   = 0,
  parameter int          OUT_MAX   = 15,
  parameter logic [22:0] LFSR_SEED = 23'h5A5A5A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [INT_W-1:0] cfg_int,
  input  logic [ACC_W-1:0] cfg_frac,
  input  logic [1:0]       cfg_order,
  input  logic             cfg_dither,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             sat
);

  // int_r + y must hold 0..2^INT_W-1 plus the -3..+4 noise excursion
  localparam int S_W = INT_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Clamp the signed divide value into the unsigned output range
  function automatic logic [OUT_W-1:0] clamp_out(input logic signed [S_W-1:0] s);
    int v;
    v = int'(s);
    if (v < OUT_MIN) return OUT_W'(OUT_MIN);
    if (v > OUT_MAX) return OUT_W'(OUT_MAX);
    return OUT_W'(v);
  endfunction

  // True when clamp_out would alter the value
  function automatic logic clamp_hit(input logic signed [S_W-1:0] s);
    int v;
    v = int'(s);
    return (v < OUT_MIN) || (v > OUT_MAX);
  endfunction

  // Noise-cancellation network; 4-bit modular arithmetic is exact for -3..4
  function automatic logic signed [3:0] mash_y(
    input logic c1, input logic c2, input logic c2d,
    input logic c3, input logic c3d, input logic c3dd
  );
    logic signed [3:0] y;
    y = $signed({3'b000, c1})
      + $signed({3'b000, c2}) - $signed({3'b000, c2d})
      + $signed({3'b000, c3}) - $signed({2'b00, c3d, 1'b0})
      + $signed({3'b000, c3dd});
    return y;
  endfunction

  state_t             state_q, state_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic [ACC_W-1:0]   frac_q, frac_d;
  logic [1:0]         order_q, order_d;
  logic               dith_q, dith_d;
  logic [ACC_W-1:0]   a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic               c2d_q, c2d_d, c3d_q, c3d_d, c3dd_q, c3dd_d;
  logic [22:0]        lfsr_q, lfsr_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               sat_q, sat_d;
  logic               cfg_ready_q, cfg_ready_d;

  logic               accept;
  logic               en1, en2, en3;
  logic               dith_bit;
  logic [ACC_W:0]     sum1, sum2, sum3;
  logic               c1, c2, c3;
  logic signed [3:0]  y;
  logic signed [S_W-1:0] s;

  assign accept = cfg_valid & cfg_ready_q;

  // Accumulator sums, carries and the clamped divide value for this edge
  always_comb begin
    en1      = (order_q != 2'd0);
    en2      = (order_q >= 2'd2);
    en3      = (order_q == 2'd3);
    dith_bit = dith_q & lfsr_q[0];
    sum1     = {1'b0, a1_q} + {1'b0, frac_q} + {{ACC_W{1'b0}}, dith_bit};
    sum2     = {1'b0, a2_q} + {1'b0, a1_q};
    sum3     = {1'b0, a3_q} + {1'b0, a2_q};
    c1       = en1 & sum1[ACC_W];
    c2       = en2 & sum2[ACC_W];
    c3       = en3 & sum3[ACC_W];
    y        = mash_y(c1, c2, c2d_q, c3, c3d_q, c3dd_q);
    s        = $signed({2'b00, int_q}) + $signed({{(S_W-4){y[3]}}, y});
  end

  // Next-state logic for the FSM, config registers and modulator state
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    frac_d  = frac_q;
    order_d = order_q;
    dith_d  = dith_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    c2d_d   = c2d_q;
    c3d_d   = c3d_q;
    c3dd_d  = c3dd_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    sat_d   = 1'b0;

    if (accept) begin
      int_d   = cfg_int;
      frac_d  = cfg_frac;
      order_d = cfg_order;
      dith_d  = cfg_dither;
    end

    case (state_q)
      S_RUN: begin
        a1_d   = en1 ? sum1[ACC_W-1:0] : '0;
        a2_d   = en2 ? sum2[ACC_W-1:0] : '0;
        a3_d   = en3 ? sum3[ACC_W-1:0] : '0;
        c2d_d  = c2;
        c3d_d  = c3;
        c3dd_d = c3d_q;
        lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
        out_d  = clamp_out(s);
        sat_d  = clamp_hit(s);
      end
      S_CLR: begin
        a1_d   = '0;
        a2_d   = '0;
        a3_d   = '0;
        c2d_d  = 1'b0;
        c3d_d  = 1'b0;
        c3dd_d = 1'b0;
      end
      default: ;
    endcase

    // An order change (or any config from IDLE) forces a clean restart
    if (accept && ((cfg_order != order_q) || (state_q == S_IDLE)))
      state_d = S_CLR;
    else
      state_d = enable ? S_RUN : S_IDLE;

    out_valid_d = (state_q == S_RUN) && (state_d == S_RUN);
    cfg_ready_d = (state_d != S_CLR);
  end

  // State registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      int_q       <= '0;
      frac_q      <= '0;
      order_q     <= '0;
      dith_q      <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      c2d_q       <= 1'b0;
      c3d_q       <= 1'b0;
      c3dd_q      <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      frac_q      <= frac_d;
      order_q     <= order_d;
      dith_q      <= dith_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      a3_q        <= a3_d;
      c2d_q       <= c2d_d;
      c3d_q       <= c3d_d;
      c3dd_q      <= c3dd_d;
      lfsr_q      <= lfsr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mash_dsm_cfg.sv
// Directed bench for mash_dsm_cfg: hand-computed output sequences for each
// order, clamp boundaries, config handshake and reset behaviour.
module tb_mash_dsm_cfg;

  localparam int ACC_W = 16;
  localparam int INT_W = 4;
  localparam int OUT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [INT_W-1:0] cfg_int;
  logic [ACC_W-1:0] cfg_frac;
  logic [1:0]       cfg_order;
  logic             cfg_dither;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             sat;

  int n_vec = 0;
  int n_err = 0;

  // Order 2, int 8, frac 1/4, starting from cleared accumulators
  int t5_out[16] = '{8, 8, 8, 10, 7, 8, 9, 9, 7, 8, 8, 10, 7, 8, 9, 9};
  // Order 3, int 14, frac 0xFFFF: early transient overshoots the clamp
  int t4_out[12] = '{14, 15, 15, 15, 14, 15, 15, 15, 15, 15, 15, 15};
  int t4_sat[12] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  // Order 2, int 0, frac 1/4: the -1 excursions hit the lower clamp
  int lo_out[9]  = '{0, 0, 0, 2, 0, 0, 1, 1, 0};
  int lo_sat[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

  mash_dsm_cfg #(
    .ACC_W(ACC_W), .INT_W(INT_W), .OUT_W(OUT_W),
    .OUT_MIN(0), .OUT_MAX(15), .LFSR_SEED(23'h5A5A5A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_order(cfg_order),
    .cfg_dither(cfg_dither),
    .out(out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int order, input int ival, input int frac, input int dith);
    cfg_valid  = 1'b1;
    cfg_order  = 2'(order);
    cfg_int    = INT_W'(ival);
    cfg_frac   = ACC_W'(frac);
    cfg_dither = 1'(dith);
    tick();
    cfg_valid  = 1'b0;
  endtask

  // After an order-changing accept: CLR cycle, then first RUN cycle, then valid
  task automatic through_clr(input string tag);
    check({tag, "_clr_ready"}, int'(cfg_ready), 0);
    check({tag, "_clr_valid"}, int'(out_valid), 0);
    tick();
    check({tag, "_run1_ready"}, int'(cfg_ready), 1);
    check({tag, "_run1_valid"}, int'(out_valid), 0);
    tick();
  endtask

  initial begin
    longint sum;
    int mn, mx, bad_valid;

    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_int = '0; cfg_frac = '0; cfg_order = '0; cfg_dither = 1'b0;
    #12;
    check("rst_out", int'(out), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_valid", int'(out_valid), 0);

    // T1: order 3, frac 0 -> constant int
    enable = 1'b1;
    send(3, 8, 0, 0);
    through_clr("t1");
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", int'(out_valid), 1);
      check("t1_out", int'(out), 8);
      check("t1_sat", int'(sat), 0);
      tick();
    end
    // Same-order update: no clear, new int visible two edges after accept
    send(3, 6, 0, 0);
    check("upd_ready", int'(cfg_ready), 1);
    check("upd_valid", int'(out_valid), 1);
    check("upd_old_out", int'(out), 8);
    tick();
    check("upd_new_out", int'(out), 6);

    // T2: order 1, frac 1/2 -> 8,9,8,9,...
    send(1, 8, 'h8000, 0);
    through_clr("t2");
    for (int i = 0; i < 10; i++) begin
      check("t2_valid", int'(out_valid), 1);
      check("t2_out", int'(out), 8 + (i % 2));
      tick();
    end

    // T3: order 3, frac 1/4, long-run average
    send(3, 8, 'h4000, 0);
    through_clr("t3");
    sum = 0; mn = 99; mx = -99; bad_valid = 0;
    for (int i = 0; i < 65536; i++) begin
      if (out_valid !== 1'b1) bad_valid++;
      sum += longint'(out);
      if (int'(out) < mn) mn = int'(out);
      if (int'(out) > mx) mx = int'(out);
      tick();
    end
    check("t3_valid_drops", bad_valid, 0);
    check("t3_sum", (sum >= 540669 && sum <= 540675) ? 540672 : int'(sum), 540672);
    check("t3_min", (mn >= 5) ? 5 : mn, 5);
    check("t3_max", (mx <= 12) ? 12 : mx, 12);

    // T5: order 3 -> 2 mid-RUN
    send(2, 8, 'h4000, 0);
    through_clr("t5");
    for (int i = 0; i < 16; i++) begin
      check("t5_valid", int'(out_valid), 1);
      check("t5_out", int'(out), t5_out[i]);
      tick();
    end

    // T4: upper clamp
    send(3, 14, 'hFFFF, 0);
    through_clr("t4");
    for (int i = 0; i < 12; i++) begin
      check("t4_out", int'(out), t4_out[i]);
      check("t4_sat", int'(sat), t4_sat[i]);
      tick();
    end

    // Enable dropped together with an order-changing accept: CLR then IDLE
    enable = 1'b0;
    send(1, 3, 'h8000, 0);
    check("edrop_clr_ready", int'(cfg_ready), 0);
    check("edrop_clr_valid", int'(out_valid), 0);
    tick();
    check("edrop_idle_ready", int'(cfg_ready), 1);
    check("edrop_idle_valid", int'(out_valid), 0);
    tick(); tick();
    check("edrop_hold_out", int'(out), 15);
    check("edrop_hold_sat", int'(sat), 0);
    enable = 1'b1;
    tick();
    check("edrop_run1_valid", int'(out_valid), 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("edrop_valid", int'(out_valid), 1);
      check("edrop_out", int'(out), 3 + (i % 2));
      tick();
    end

    // Order 0 bypass
    send(0, 9, 'h8000, 0);
    through_clr("byp");
    for (int i = 0; i < 4; i++) begin
      check("byp_out", int'(out), 9);
      tick();
    end

    // Lower clamp
    send(2, 0, 'h4000, 0);
    through_clr("lo");
    for (int i = 0; i < 9; i++) begin
      check("lo_out", int'(out), lo_out[i]);
      check("lo_sat", int'(sat), lo_sat[i]);
      tick();
    end

    // T6: async reset mid-RUN, then T1 again
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out", int'(out), 0);
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_ready", int'(cfg_ready), 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send(3, 8, 0, 0);
    through_clr("t6");
    for (int i = 0; i < 6; i++) begin
      check("t6_valid", int'(out_valid), 1);
      check("t6_out", int'(out), 8);
      check("t6_sat", int'(sat), 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
